// File: rtl/wb_uart_cmd_master.sv
// UART byte-stream command bridge acting as a pipelined Wishbone master.
// Executes single 32-bit read/write commands and streams back status/data.
module wb_uart_cmd_master #(
  parameter int BUS_TIMEOUT = 1024,
  parameter int RX_TIMEOUT  = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i
);

  localparam int TW = $clog2(BUS_TIMEOUT + 1);
  localparam int RW = $clog2(RX_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [31:0]   rdat_q, rdat_d;
  logic [7:0]    status_q, status_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] idle_q, idle_d;
  logic [2:0]    idx_q, idx_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic          txv_q, txv_d;
  logic [7:0]    txd_q, txd_d;
  logic          rxr_q, rxr_d;
  logic          acc;
  logic [2:0]    last;

  assign acc = rx_valid & rxr_q;
  assign last = (status_q == 8'h00 && !wr_q) ? 3'd4 : 3'd0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    rdat_d   = rdat_q;
    status_d = status_q;
    tmo_d    = tmo_q;
    idle_d   = idle_q;
    idx_d    = idx_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    txv_d    = txv_q;
    txd_d    = txd_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d  = 2'd0;
        idle_d = '0;
        if (acc) begin
          if (rx_data == 8'h01 || rx_data == 8'h02) begin
            wr_d    = (rx_data == 8'h01);
            state_d = S_ADDR;
          end else begin
            status_d = 8'hFF;
            state_d  = S_RESP;
            txv_d    = 1'b1;
            txd_d    = 8'hFF;
            idx_d    = 3'd0;
          end
        end
      end
      S_ADDR, S_DATA: begin
        if (acc) begin
          idle_d = '0;
          cnt_d  = cnt_q + 2'd1;
          if (state_q == S_ADDR) adr_d = {adr_q[23:0], rx_data};
          else                   dat_d = {dat_q[23:0], rx_data};
          if (cnt_q == 2'd3) begin
            if (state_q == S_ADDR && wr_q) begin
              state_d = S_DATA;
            end else begin
              state_d = S_BUS;
              cyc_d   = 1'b1;
              stb_d   = 1'b1;
              we_d    = wr_q;
              tmo_d   = '0;
            end
          end
        end else if (idle_q == RW'(RX_TIMEOUT - 1)) begin
          state_d = S_IDLE;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + RW'(1);
        end
      end
      S_BUS: begin
        tmo_d = tmo_q + TW'(1);
        if (stb_q && !wb_stall_i) stb_d = 1'b0;
        if (wb_ack_i || wb_err_i || tmo_q == TW'(BUS_TIMEOUT - 1)) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          if (wb_err_i)      status_d = 8'hE0;
          else if (wb_ack_i) status_d = 8'h00;
          else               status_d = 8'hE1;
          if (wb_ack_i && !wb_err_i && !wr_q) rdat_d = wb_dat_i;
          state_d = S_RESP;
          txv_d   = 1'b1;
          txd_d   = status_d;
          idx_d   = 3'd0;
        end
      end
      S_RESP: begin
        if (tx_ready) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == last) begin
            txv_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            case (idx_d)
              3'd1:    txd_d = rdat_q[31:24];
              3'd2:    txd_d = rdat_q[23:16];
              3'd3:    txd_d = rdat_q[15:8];
              default: txd_d = rdat_q[7:0];
            endcase
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    rxr_d = (state_d == S_IDLE) || (state_d == S_ADDR) ||
            (state_d == S_DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      wr_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      rdat_q   <= '0;
      status_q <= '0;
      tmo_q    <= '0;
      idle_q   <= '0;
      idx_q    <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      txv_q    <= 1'b0;
      txd_q    <= '0;
      rxr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      rdat_q   <= rdat_d;
      status_q <= status_d;
      tmo_q    <= tmo_d;
      idle_q   <= idle_d;
      idx_q    <= idx_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      txv_q    <= txv_d;
      txd_q    <= txd_d;
      rxr_q    <= rxr_d;
    end
  end

  assign rx_ready = rxr_q;
  assign tx_valid = txv_q;
  assign tx_data  = txd_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q & 32'hFFFF_FFFC;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = 4'hF;

endmodule

// File: tb/tb_wb_uart_cmd_master.sv
// Directed bench for wb_uart_cmd_master with a small Wishbone slave model.
module tb_wb_uart_cmd_master;

  localparam int BT = 16;
  localparam int RT = 40;

  logic        clk, rst;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i, wb_stall_i;

  wb_uart_cmd_master #(.BUS_TIMEOUT(BT), .RX_TIMEOUT(RT)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_stall_i(wb_stall_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // slave model state
  int          mode = 0;
  int          ack_dly = 0;
  int          stall_left = 0;
  int          pend = 0;
  int          ntx = 0;
  int          stb_cnt = 0;
  int          cyc_cnt = 0;
  logic [31:0] rdata = '0;
  logic [31:0] cap_adr, cap_dat;
  logic        cap_we;
  logic [3:0]  cap_sel;

  task automatic respond();
    if (mode == 0) begin
      wb_ack_i = 1'b1;
      wb_dat_i = rdata;
    end else if (mode == 1) begin
      wb_err_i = 1'b1;
    end
  endtask

  initial begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_stall_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (wb_cyc_o) cyc_cnt++;
      else pend = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) respond();
      end
      if (wb_cyc_o && wb_stb_o) begin
        stb_cnt++;
        if (stall_left > 0) begin
          wb_stall_i = 1'b1;
          stall_left--;
        end else begin
          wb_stall_i = 1'b0;
          ntx++;
          cap_adr = wb_adr_o;
          cap_dat = wb_dat_o;
          cap_we  = wb_we_o;
          cap_sel = wb_sel_o;
          if (ack_dly == 0) respond();
          else pend = ack_dly;
        end
      end else begin
        wb_stall_i = 1'b0;
      end
    end
  end

  logic [7:0] resp_q[$];
  always @(negedge clk)
    if (!rst && tx_valid && tx_ready) resp_q.push_back(tx_data);

  function automatic logic [31:0] rb(input int i);
    if (i < resp_q.size()) return {24'h0, resp_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic setup(input int m, input int d, input int s,
                       input logic [31:0] rd);
    mode = m;
    ack_dly = d;
    stall_left = s;
    rdata = rd;
    ntx = 0;
    stb_cnt = 0;
    cyc_cnt = 0;
    resp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int k;
    rx_data = b;
    rx_valid = 1'b1;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 100) begin
      acc = rx_ready;
      @(posedge clk); #1;
      k++;
    end
    rx_valid = 1'b0;
    if (!acc) chk("rx_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [31:0] a);
    send_byte(c);
    send_byte(a[31:24]);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic wait_resp(input string tag, input int n);
    int k;
    k = 0;
    while (resp_q.size() < n && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk({tag, "_len"}, resp_q.size(), n);
  endtask

  initial begin
    int unst;
    int k;
    logic [7:0] b0;
    rst = 1'b1;
    rx_data = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {27'h0, rx_ready, tx_valid, wb_cyc_o, wb_stb_o, wb_we_o},
        32'h0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_txd", {24'h0, tx_data}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_rdy", {31'h0, rx_ready}, 32'h1);

    // write, ack two cycles after stb
    setup(0, 2, 0, 32'h0);
    send_cmd(8'h01, 32'h1000_0000);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    chk("wr_lat", {31'h0, wb_cyc_o}, 32'h1);
    wait_resp("wr", 1);
    chk("wr_ntx", ntx, 1);
    chk("wr_adr", cap_adr, 32'h1000_0000);
    chk("wr_dat", cap_dat, 32'hDEAD_BEEF);
    chk("wr_we", {31'h0, cap_we}, 32'h1);
    chk("wr_sel", {28'h0, cap_sel}, 32'hF);
    chk("wr_b0", rb(0), 32'h00);

    // read with 3 stall cycles, ack while stb still high
    setup(0, 0, 3, 32'h1234_5678);
    send_cmd(8'h02, 32'h0000_0005);
    wait_resp("rd", 5);
    chk("rd_adr", cap_adr, 32'h0000_0004);
    chk("rd_we", {31'h0, cap_we}, 32'h0);
    chk("rd_stb", stb_cnt, 4);
    chk("rd_b0", rb(0), 32'h00);
    chk("rd_b1", rb(1), 32'h12);
    chk("rd_b2", rb(2), 32'h34);
    chk("rd_b3", rb(3), 32'h56);
    chk("rd_b4", rb(4), 32'h78);

    // bus error
    setup(1, 1, 0, 32'h0);
    send_cmd(8'h02, 32'h0000_0008);
    wait_resp("err", 1);
    chk("err_b0", rb(0), 32'hE0);

    // bus timeout
    setup(2, 0, 0, 32'h0);
    send_cmd(8'h02, 32'h0000_0010);
    wait_resp("tmo", 1);
    chk("tmo_cyc", cyc_cnt, BT);
    chk("tmo_b0", rb(0), 32'hE1);

    // unknown command
    setup(0, 1, 0, 32'h0);
    send_byte(8'h7A);
    wait_resp("unk", 1);
    chk("unk_b0", rb(0), 32'hFF);
    chk("unk_idle", {31'h0, rx_ready}, 32'h1);

    // partial command discarded by inter-byte timeout
    setup(0, 1, 0, 32'hCAFE_F00D);
    send_byte(8'h02);
    send_byte(8'h00);
    repeat (RT + 5) @(posedge clk);
    #1;
    send_cmd(8'h02, 32'h0000_0000);
    wait_resp("rxto", 5);
    chk("rxto_ntx", ntx, 1);
    chk("rxto_adr", cap_adr, 32'h0);
    chk("rxto_b0", rb(0), 32'h00);
    chk("rxto_b4", rb(4), 32'h0D);

    // tx backpressure
    setup(0, 1, 0, 32'hA1B2_C3D4);
    tx_ready = 1'b0;
    send_cmd(8'h02, 32'h0000_0020);
    k = 0;
    while (!tx_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_valid", {31'h0, tx_valid}, 32'h1);
    b0 = tx_data;
    unst = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (tx_data !== b0 || !tx_valid) unst++;
    end
    chk("bp_stable", unst, 0);
    chk("bp_first", {24'h0, b0}, 32'h00);
    tx_ready = 1'b1;
    wait_resp("bp", 5);
    chk("bp_b0", rb(0), 32'h00);
    chk("bp_b1", rb(1), 32'hA1);
    chk("bp_b2", rb(2), 32'hB2);
    chk("bp_b3", rb(3), 32'hC3);
    chk("bp_b4", rb(4), 32'hD4);

    // reset mid-transaction
    setup(2, 0, 0, 32'h0);
    send_cmd(8'h02, 32'h0000_0040);
    chk("mr_cyc_pre", {31'h0, wb_cyc_o}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mr_ctl", {29'h0, wb_cyc_o, wb_stb_o, tx_valid}, 32'h0);
    chk("mr_rdy0", {31'h0, rx_ready}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mr_rdy1", {31'h0, rx_ready}, 32'h1);
    repeat (30) @(posedge clk);
    #1;
    chk("mr_noresp", resp_q.size(), 0);
    chk("mr_cyc_post", {31'h0, wb_cyc_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_uart_cmd_master.md
Name: wb_uart_cmd_master

Overview:
- Byte-stream-to-Wishbone bridge; an additional bus master on the shared-bus interconnect, alongside the core instruction, core data and debug masters.
- Consumes received bytes from a UART receiver and executes single 32-bit read/write transactions on pipelined Wishbone.
- Returns status and read data as bytes to the UART transmitter.
- Provides host-side memory/peripheral poke without JTAG.

Parameters:
- BUS_TIMEOUT, 1024, cycles to wait for ack/err after stb before aborting the cycle (≥2).
- RX_TIMEOUT, 100000, idle cycles allowed between bytes of one command before discard (≥2).

Ports:
- clk  in  1  system clock, shared with the interconnect.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid; byte consumed on a cycle with rx_valid & rx_ready.
- rx_ready  out  1  bridge accepts a byte.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid; held stable until tx_ready.
- tx_ready  in  1  transmitter accepts tx_data.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  32  byte address; bits [1:0] forced 0.
- wb_dat_o  out  32  write data.
- wb_sel_o  out  4  byte selects, constant 4'hF.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  acknowledge.
- wb_err_i  in  1  error.
- wb_stall_i  in  1  pipelined stall.

Behaviour:
- Reset: clk and rst only; rst is synchronous and active-high.
  - All outputs registered.
  - During rst: rx_ready=0, tx_valid=0, tx_data=0, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0.
  - State returns to IDLE and all counters clear.
  - rst mid-transaction drops cyc/stb at that edge; no response is sent.
- Command format, multi-byte fields MSB first:
  - 0x01 = write: 1 cmd byte + 4 address bytes + 4 data bytes.
  - 0x02 = read: 1 cmd byte + 4 address bytes.
- Response bytes:
  - Write: status only.
  - Read: status, then 4 data bytes MSB first, sent only when status = 0x00.
  - Status codes: 0x00 ok, 0xE0 bus error (err), 0xE1 bus timeout, 0xFF unknown command.
- State machine:
  - IDLE: rx_ready=1. Cmd byte 0x01/0x02 → ADDR with byte count 0. Any other byte → RESP with status 0xFF.
  - ADDR: rx_ready=1; shift 4 bytes into the address register. After the 4th: write → DATA, read → BUS.
  - DATA: rx_ready=1; shift 4 bytes into the data register. After the 4th → BUS.
  - BUS:
    - rx_ready=0.
    - Cycle after entry: cyc=stb=1, we per command.
    - stb deasserts on the first edge where stb & !stall; cyc holds.
    - First ack or err ends the cycle: cyc=0 the next cycle.
    - Ack → status 0x00 and latch wb_dat_i if read. Err → status 0xE0. Ack and err together count as err.
    - Ack/err arriving while stb is still high (same cycle the stall clears) is valid.
    - Timeout counter starts when stb asserts. After BUS_TIMEOUT cycles without ack/err: cyc=stb=0, status 0xE1.
    - → RESP.
  - RESP: rx_ready=0.
    - tx_valid=1 with the status byte.
    - Each tx_valid & tx_ready advances to the next byte; tx_valid stays high between back-to-back bytes.
    - After the last byte, tx_valid=0 and → IDLE.
- Inter-byte timeout:
  - In ADDR/DATA, an idle counter resets on each accepted byte.
  - Reaching RX_TIMEOUT returns to IDLE silently and discards the partial command.
  - A byte accepted on the same cycle the timeout is reached wins: it is consumed and the counter clears.
- Bytes offered while rx_ready=0 are not consumed; backpressure is on the receiver.
- Minimum latency, last command byte accepted → cyc high: 1 cycle.
- Zero-wait slave, ack 1 cycle after stb: status tx_valid 2 cycles after the ack edge at the latest.

Test Plan:
- Write: bytes 01 10 00 00 00 DE AD BE EF; slave acks 2 cycles after stb → one bus cycle with adr=0x10000000, dat_o=0xDEADBEEF, we=1, sel=F; response byte 0x00.
- Read: bytes 02 00 00 00 05; slave returns 0x12345678 with ack, stall high for 3 cycles → adr=0x00000004, stb held through the stall then dropped; response 00 12 34 56 78.
- Error/timeout:
  - Read with slave asserting err → response 0xE0 only.
  - Slave never responding → cyc drops after exactly BUS_TIMEOUT cycles; response 0xE1.
- Framing:
  - Byte 0x7A → response 0xFF, back in IDLE.
  - Send 02 00 then stall RX_TIMEOUT cycles, then 02 00 00 00 00 → only the second command executes (adr=0).
- Backpressure/reset:
  - tx_ready held low 10 cycles during a read response → tx_data stable, no byte lost.
  - rst asserted while cyc=1 → cyc=stb=tx_valid=0 after that edge; rx_ready=1 the cycle after rst deasserts; no response emitted.
